// File: rtl/shrg_vram_responder_pkg.sv
// Shared types and constants for the Super Hires VRAM responder.
// A queued bus write is one byte headed for one lane of one 32-bit VRAM word.
package shrg_vram_responder_pkg;

   // Bank $E1 byte window that is mirrored into VRAM.
   localparam logic [15:0] SHRG_BASE  = 16'h2000;
   localparam logic [15:0] SHRG_LIMIT = 16'h9FFF;

   localparam int VRAM_WORDS = 8192;
   localparam int VRAM_AW    = 13;

   typedef logic [VRAM_AW-1:0] vram_addr_t;

   typedef struct packed {
      vram_addr_t  word;
      logic [1:0]  lane;
      logic [7:0]  data;
   } shrg_wr_t;

   // One-hot byte enable for a lane; lane 0 is bits [7:0].
   function automatic logic [3:0] shrg_lane_mask(input logic [1:0] lane);
      logic [3:0] mask;
      mask = 4'b0001 << lane;
      return mask;
   endfunction

endpackage

// File: rtl/shrg_vram_responder_if.sv
// Bus-side and display-side signal bundle of the VRAM responder.
// The slave modport is the responder; the master modport is whoever drives the
// Apple bus writes and the display fetcher reads.
interface shrg_vram_responder_if
   import shrg_vram_responder_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
);

   // Apple II bus write side
   logic                          bus_wr_i;
   logic [15:0]                   bus_addr_i;
   logic                          bus_bank_e1_i;
   logic [7:0]                    bus_data_i;
   logic                          shadow_en_i;

   // Display fetcher read side
   logic                          vgc_rd_i;
   vram_addr_t                    vgc_address_i;
   logic [31:0]                   vgc_data_o;
   logic                          vgc_valid_o;

   // Status
   logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;
   logic                          overflow_o;

   modport slave (
      input  bus_wr_i,
      input  bus_addr_i,
      input  bus_bank_e1_i,
      input  bus_data_i,
      input  shadow_en_i,
      input  vgc_rd_i,
      input  vgc_address_i,
      output vgc_data_o,
      output vgc_valid_o,
      output fifo_level_o,
      output overflow_o
   );

   modport master (
      output bus_wr_i,
      output bus_addr_i,
      output bus_bank_e1_i,
      output bus_data_i,
      output shadow_en_i,
      output vgc_rd_i,
      output vgc_address_i,
      input  vgc_data_o,
      input  vgc_valid_o,
      input  fifo_level_o,
      input  overflow_o
   );

endinterface

// File: rtl/shrg_vram_responder_wr_fifo.sv
// Small synchronous FIFO holding bus writes until the VRAM port is free.
// A push into a full queue is still taken when a pop happens in the same cycle.
module shrg_vram_responder_wr_fifo
   import shrg_vram_responder_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  shrg_wr_t                 push_data,
   input  logic                     pop,
   output shrg_wr_t                 pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   shrg_wr_t         entry_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic [LW-1:0]    level_next;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (level_reg == LW'(DEPTH));
   assign empty    = (level_reg == '0);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign level    = level_reg;
   assign pop_data = entry_reg[rd_ptr_reg];

   // Occupancy: a simultaneous push and pop leaves the level unchanged.
   always_comb begin
      level_next = level_reg;
      unique case ({push_ok, pop_ok})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   // Pointer and level registers; reset flushes the queue.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         level_reg <= level_next;
      end
   end

   // Entry storage; contents are don't-care after a flush, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) entry_reg[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/shrg_vram_responder.sv
// Memory-side responder for the Super Hires display fetcher.
// Owns the single-port 32-bit VRAM. Bus byte writes to $E1:2000-$9FFF are
// queued; display reads always win the port and return data two cycles after
// the rising edge of vgc_rd_i. Reads see RAM contents only (no forwarding from
// the queue), which the display tolerates as one frame of staleness.
module shrg_vram_responder #(
   parameter int          FIFO_DEPTH = 8,
   parameter int          VRAM_WORDS = 8192,
   parameter logic [15:0] SHRG_BASE  = shrg_vram_responder_pkg::SHRG_BASE,
   parameter logic [15:0] SHRG_LIMIT = shrg_vram_responder_pkg::SHRG_LIMIT
)(
   input  logic                  clk_logic,
   input  logic                  system_reset,
   shrg_vram_responder_if.slave  vif
);

   import shrg_vram_responder_pkg::*;

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   // ---------------------------------------------------------------
   // Bus write qualify and address map
   // ---------------------------------------------------------------
   logic          wr_in_window;
   logic          wr_qualify;
   logic [15:0]   wr_offset;
   shrg_wr_t      wr_entry;

   assign wr_in_window = (vif.bus_addr_i >= SHRG_BASE) && (vif.bus_addr_i <= SHRG_LIMIT);
   assign wr_qualify   = vif.bus_wr_i & vif.shadow_en_i & vif.bus_bank_e1_i & wr_in_window;
   assign wr_offset    = vif.bus_addr_i - SHRG_BASE;
   assign wr_entry     = '{word: wr_offset[14:2], lane: wr_offset[1:0], data: vif.bus_data_i};

   // ---------------------------------------------------------------
   // Read request edge detect
   // ---------------------------------------------------------------
   logic          vgc_rd_q;
   logic          rd_edge;
   logic          rd_pend_reg;
   vram_addr_t    rd_addr_reg;

   assign rd_edge = vif.vgc_rd_i & ~vgc_rd_q;

   // Capture the word address on the rising edge of the read request; the
   // pending flag lives exactly one cycle because rd is at least two cycles wide.
   always_ff @(posedge clk_logic) begin
      if (system_reset) begin
         vgc_rd_q    <= 1'b0;
         rd_pend_reg <= 1'b0;
         rd_addr_reg <= '0;
      end else begin
         vgc_rd_q    <= vif.vgc_rd_i;
         rd_pend_reg <= rd_edge;
         if (rd_edge) rd_addr_reg <= vif.vgc_address_i;
      end
   end

   // ---------------------------------------------------------------
   // Write queue and arbiter
   // ---------------------------------------------------------------
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   shrg_wr_t      fifo_head;
   logic [LW-1:0] fifo_level;

   // The pending read owns the port; otherwise drain one queued byte.
   assign fifo_push = wr_qualify & ~system_reset;
   assign fifo_pop  = ~system_reset & ~rd_pend_reg & ~fifo_empty;

   shrg_vram_responder_wr_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk_logic),
      .srst      (system_reset),
      .push      (fifo_push),
      .push_data (wr_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   logic          overflow_reg;

   // Sticky drop flag: a qualified write hit a full queue with no pop to free a slot.
   always_ff @(posedge clk_logic) begin
      if (system_reset) begin
         overflow_reg <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
         overflow_reg <= 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Byte-enable VRAM
   // ---------------------------------------------------------------
   logic [31:0]   vram_mem [VRAM_WORDS];
   logic [3:0]    ram_be;
   logic [3:0]    lane_mask;

   assign lane_mask = shrg_lane_mask(fifo_head.lane);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane_be
         assign ram_be[gi] = fifo_pop & lane_mask[gi];
      end
   endgenerate

   // Lane-masked write of one dequeued byte.
   always_ff @(posedge clk_logic) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_be[b]) vram_mem[fifo_head.word][b*8 +: 8] <= fifo_head.data;
      end
   end

   logic [31:0]   vgc_data_reg;
   logic          vgc_valid_reg;

   // Registered read straight into the held output word, one cycle after the
   // request is pending; reset drops any read in flight and zeroes the word.
   always_ff @(posedge clk_logic) begin
      if (system_reset) begin
         vgc_data_reg  <= '0;
         vgc_valid_reg <= 1'b0;
      end else begin
         vgc_valid_reg <= rd_pend_reg;
         if (rd_pend_reg) vgc_data_reg <= vram_mem[rd_addr_reg];
      end
   end

   assign vif.vgc_data_o   = vgc_data_reg;
   assign vif.vgc_valid_o  = vgc_valid_reg;
   assign vif.fifo_level_o = fifo_level;
   assign vif.overflow_o   = overflow_reg;

endmodule

// File: tb/tb_shrg_vram_responder.sv
// Directed bench for the SHRG VRAM responder: reset state, byte-lane mapping,
// address window boundaries, read priority over queued writes, and queue overflow.
module tb_shrg_vram_responder;

   logic clk_logic    = 1'b0;
   logic system_reset = 1'b1;

   always #5 clk_logic = ~clk_logic;

   shrg_vram_responder_if #(.FIFO_DEPTH(8)) vif ();

   shrg_vram_responder #(
      .FIFO_DEPTH   (8),
      .VRAM_WORDS   (8192)
   ) dut (
      .clk_logic    (clk_logic),
      .system_reset (system_reset),
      .vif          (vif)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clk_logic);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                            input logic bank = 1'b1, input logic sh = 1'b1);
      vif.bus_wr_i      = 1'b1;
      vif.bus_addr_i    = a;
      vif.bus_data_i    = d;
      vif.bus_bank_e1_i = bank;
      vif.shadow_en_i   = sh;
      cyc();
      vif.bus_wr_i      = 1'b0;
      vif.bus_bank_e1_i = 1'b1;
      vif.shadow_en_i   = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 32 && vif.fifo_level_o != 0; i++) cyc();
      check(tag, 32'(vif.fifo_level_o), 32'd0);
   endtask

   // Read one word: valid must stay low at T+1, pulse with data at T+2, then data holds.
   task automatic do_read(input logic [12:0] w, input logic [31:0] exp, input string tag);
      vif.vgc_rd_i      = 1'b1;
      vif.vgc_address_i = w;
      cyc();
      check({tag, "_t1_valid"}, 32'(vif.vgc_valid_o), 32'd0);
      cyc();
      check({tag, "_valid"}, 32'(vif.vgc_valid_o), 32'd1);
      check({tag, "_data"}, vif.vgc_data_o, exp);
      vif.vgc_rd_i = 1'b0;
      cyc();
      check({tag, "_pulse_end"}, 32'(vif.vgc_valid_o), 32'd0);
      check({tag, "_hold"}, vif.vgc_data_o, exp);
   endtask

   initial begin
      logic [12:0] clear_words [6];
      int          exp_level;

      clear_words = '{13'd0, 13'd4, 13'd100 + 13'd3, 13'd104, 13'd1024, 13'd8191};

      vif.bus_wr_i      = 1'b0;
      vif.bus_addr_i    = '0;
      vif.bus_bank_e1_i = 1'b1;
      vif.bus_data_i    = '0;
      vif.shadow_en_i   = 1'b1;
      vif.vgc_rd_i      = 1'b0;
      vif.vgc_address_i = '0;

      // Reset state
      repeat (3) cyc();
      check("rst_data",     vif.vgc_data_o, 32'd0);
      check("rst_valid",    32'(vif.vgc_valid_o), 32'd0);
      check("rst_level",    32'(vif.fifo_level_o), 32'd0);
      check("rst_overflow", 32'(vif.overflow_o), 32'd0);
      system_reset = 1'b0;
      cyc();

      // Zero every word the bench later reads back
      foreach (clear_words[i]) begin
         for (int l = 0; l < 4; l++) begin
            bus_write(16'h2000 + {1'b0, clear_words[i], 2'b00} + 16'(l), 8'h00);
         end
      end
      wait_drain("clear_drain");
      do_read(13'd0, 32'h0000_0000, "rd_w0_zero");

      // Four lanes of word 0
      bus_write(16'h2000, 8'h11);
      bus_write(16'h2001, 8'h22);
      bus_write(16'h2002, 8'h33);
      bus_write(16'h2003, 8'h44);
      wait_drain("w0_drain");
      do_read(13'd0, 32'h4433_2211, "rd_w0_lanes");

      // Word 8001 preload then single-lane update
      bus_write(16'h9D04, 8'hDD);
      bus_write(16'h9D05, 8'hCC);
      bus_write(16'h9D06, 8'hBB);
      bus_write(16'h9D07, 8'hAA);
      wait_drain("w8001_drain");
      do_read(13'd8001, 32'hAABB_CCDD, "rd_w8001_pre");
      bus_write(16'h9D05, 8'h80);
      wait_drain("w8001_upd_drain");
      do_read(13'd8001, 32'hAABB_80DD, "rd_w8001_lane1");

      // Writes outside the window, wrong bank, or with shadowing off are dropped
      bus_write(16'h1FFF, 8'hEE);
      check("ign_1fff_level", 32'(vif.fifo_level_o), 32'd0);
      bus_write(16'hA000, 8'hEE);
      check("ign_a000_level", 32'(vif.fifo_level_o), 32'd0);
      bus_write(16'h2000, 8'hEE, 1'b0, 1'b1);
      check("ign_e0_level", 32'(vif.fifo_level_o), 32'd0);
      bus_write(16'h3000, 8'hEE, 1'b1, 1'b0);
      check("ign_shadow_level", 32'(vif.fifo_level_o), 32'd0);
      cyc();
      do_read(13'd0,    32'h4433_2211, "rd_ign_w0");
      do_read(13'd8191, 32'h0000_0000, "rd_ign_w8191");
      do_read(13'd1024, 32'h0000_0000, "rd_ign_w1024");

      // Top of the window lands in the last word, lane 3
      bus_write(16'h9FFF, 8'h5A);
      wait_drain("w9fff_drain");
      do_read(13'd8191, 32'h5A00_0000, "rd_w8191_lane3");

      // Three queued writes with a read edge in the third push cycle
      vif.bus_wr_i = 1'b1; vif.bus_addr_i = 16'h2010; vif.bus_data_i = 8'hAA;
      cyc();
      check("p3_level_a", 32'(vif.fifo_level_o), 32'd1);
      vif.bus_addr_i = 16'h2011; vif.bus_data_i = 8'hBB;
      cyc();
      check("p3_level_b", 32'(vif.fifo_level_o), 32'd1);
      vif.bus_addr_i = 16'h2012; vif.bus_data_i = 8'hCC;
      vif.vgc_rd_i = 1'b1; vif.vgc_address_i = 13'd0;
      cyc();
      vif.bus_wr_i = 1'b0;
      check("p3_t1_valid", 32'(vif.vgc_valid_o), 32'd0);
      check("p3_t1_level", 32'(vif.fifo_level_o), 32'd1);
      cyc();
      check("p3_t2_valid", 32'(vif.vgc_valid_o), 32'd1);
      check("p3_t2_data",  vif.vgc_data_o, 32'h4433_2211);
      check("p3_t2_level", 32'(vif.fifo_level_o), 32'd1);
      vif.vgc_rd_i = 1'b0;
      cyc();
      check("p3_t3_level", 32'(vif.fifo_level_o), 32'd0);
      do_read(13'd4, 32'h00CC_BBAA, "rd_w4_p3");

      // 20 back-to-back writes while rd toggles every cycle: pops only on
      // alternate cycles, so the queue fills and writes 15, 17, 19 are dropped
      for (int k = 0; k < 20; k++) begin
         vif.bus_wr_i      = 1'b1;
         vif.bus_addr_i    = 16'h2190 + 16'(k);
         vif.bus_data_i    = 8'(k + 1);
         vif.vgc_rd_i      = (k % 2 == 0);
         vif.vgc_address_i = 13'd0;
         cyc();
         exp_level = (k + 3) / 2;
         if (exp_level > 8) exp_level = 8;
         check($sformatf("ovf_level_k%0d", k), 32'(vif.fifo_level_o), 32'(exp_level));
         check($sformatf("ovf_flag_k%0d", k), 32'(vif.overflow_o), (k >= 15) ? 32'd1 : 32'd0);
      end
      vif.bus_wr_i = 1'b0;
      vif.vgc_rd_i = 1'b0;
      cyc();
      wait_drain("ovf_drain");
      check("ovf_sticky", 32'(vif.overflow_o), 32'd1);
      do_read(13'd100, 32'h0403_0201, "rd_w100");
      do_read(13'd102, 32'h0C0B_0A09, "rd_w102");
      do_read(13'd103, 32'h000F_0E0D, "rd_w103_drop");
      do_read(13'd104, 32'h0013_0011, "rd_w104_drop");

      // Reset arriving while a read is pending abandons it
      vif.vgc_rd_i = 1'b1; vif.vgc_address_i = 13'd0;
      cyc();
      system_reset = 1'b1;
      cyc();
      check("rst2_data",     vif.vgc_data_o, 32'd0);
      check("rst2_valid",    32'(vif.vgc_valid_o), 32'd0);
      check("rst2_overflow", 32'(vif.overflow_o), 32'd0);
      check("rst2_level",    32'(vif.fifo_level_o), 32'd0);
      vif.vgc_rd_i = 1'b0;
      system_reset = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
